// File: rtl/smart_ac_status_decoder.sv
// smart_ac_status_decoder
//
// Watches the status outputs of an air-conditioner controller (mode, fan
// speed and the seven-segment digit it is showing) and reports each new
// stable status tuple once. A tuple counts as stable after STABLE_CYCLES
// consecutive identical registered samples. Each accepted tuple is checked
// for display/mode consistency, an out-of-range mode and an illegal mode
// jump. The errors are also folded into a sticky flag, and accepted tuples
// are counted.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   mode[2:0]     controller mode being monitored (legal 0..4)
//   fan[2:0]      fan-speed code, passed through uninterpreted
//   disp[6:0]     seven-segment pattern {g,f,e,d,c,b,a}, active-high
//   clr           synchronous clear of err_sticky and change_count
//   status_valid  one-cycle pulse: a new stable tuple was accepted
//   status_mode   mode of the last accepted tuple
//   status_fan    fan of the last accepted tuple
//   err_disp      display pattern is not a legal digit 0..4   (with pulse)
//   err_mismatch  legal digit differs from mode               (with pulse)
//   err_range     mode greater than 4                         (with pulse)
//   err_jump      mode moved by more than one step            (with pulse)
//   err_sticky    OR of all per-event errors since reset/clr
//   change_count  accepted tuples, saturating at 255

module smart_ac_status_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic [2:0] fan,
  input  logic [6:0] disp,
  input  logic       clr,
  output logic       status_valid,
  output logic [2:0] status_mode,
  output logic [2:0] status_fan,
  output logic       err_disp,
  output logic       err_mismatch,
  output logic       err_range,
  output logic       err_jump,
  output logic       err_sticky,
  output logic [7:0] change_count
);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [4:0] STABLE_W = 5'(STABLE_CYCLES);

  // Legal display patterns, index = digit shown.
  localparam logic [6:0] SEG_PAT [5] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110   // 4
  };

  // ---------------------------------------------------------------------
  // Sample pipeline: current sample and the one before it.
  // The valid flags make the first sample after reset count as "changed",
  // so a tuple equal to the pre-reset one (or all zeros) is still reported.
  // ---------------------------------------------------------------------
  logic [12:0] sample_reg;
  logic [12:0] prev_reg;
  logic        s_vld_reg;
  logic        p_vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      prev_reg   <= '0;
      s_vld_reg  <= 1'b0;
      p_vld_reg  <= 1'b0;
    end else begin
      sample_reg <= {mode, fan, disp};
      prev_reg   <= sample_reg;
      s_vld_reg  <= 1'b1;
      p_vld_reg  <= s_vld_reg;
    end
  end

  logic [2:0] s_mode;
  logic [2:0] s_fan;
  logic [6:0] s_disp;

  assign s_mode = sample_reg[12:10];
  assign s_fan  = sample_reg[9:7];
  assign s_disp = sample_reg[6:0];

  // ---------------------------------------------------------------------
  // Display decoding
  // ---------------------------------------------------------------------
  logic [4:0] pat_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_seg
      assign pat_hit[gi] = (s_disp == SEG_PAT[gi]);
    end
  endgenerate

  logic [2:0] disp_digit;
  logic       disp_legal;

  always_comb begin
    disp_digit = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (pat_hit[i]) disp_digit = 3'(i);
    end
    disp_legal = |pat_hit;
  end

  // ---------------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------------
  logic [0:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       sample_changed;
  logic       lock_now;

  // Until two samples exist there is nothing to compare against, which is
  // treated the same as a change.
  assign sample_changed = !p_vld_reg || (sample_reg != prev_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_now   = 1'b0;
    if (s_vld_reg) begin
      if (sample_changed) begin
        state_next = ST_SETTLE;
        cnt_next   = 4'd1;
      end else if (state_reg == ST_SETTLE) begin
        if ({1'b0, cnt_reg} + 5'd1 >= STABLE_W) begin
          state_next = ST_LOCKED;
          cnt_next   = STABLE_W[3:0];
          lock_now   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_SETTLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Acceptance and event checks
  // ---------------------------------------------------------------------
  logic        have_last_reg;
  logic [12:0] last_reg;
  logic        accept;
  logic [2:0]  last_mode;
  logic [2:0]  mode_delta;
  logic        ev_disp;
  logic        ev_mismatch;
  logic        ev_range;
  logic        ev_jump;
  logic        ev_any;

  // Re-locking onto the tuple already reported (e.g. after a glitch) is
  // silent; only a genuinely new tuple produces a pulse.
  assign accept = lock_now && (!have_last_reg || (sample_reg != last_reg));

  assign last_mode  = last_reg[12:10];
  assign mode_delta = (s_mode > last_mode) ? (s_mode - last_mode)
                                           : (last_mode - s_mode);

  assign ev_disp     = !disp_legal;
  assign ev_mismatch = disp_legal && (disp_digit != s_mode);
  assign ev_range    = (s_mode > 3'd4);
  // Dropping back to mode 0 (off) is always allowed.
  assign ev_jump     = have_last_reg && (s_mode != 3'd0) && (mode_delta > 3'd1);
  assign ev_any      = ev_disp || ev_mismatch || ev_range || ev_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_last_reg <= 1'b0;
      last_reg      <= '0;
      status_valid  <= 1'b0;
      status_mode   <= 3'd0;
      status_fan    <= 3'd0;
      err_disp      <= 1'b0;
      err_mismatch  <= 1'b0;
      err_range     <= 1'b0;
      err_jump      <= 1'b0;
    end else begin
      status_valid <= accept;
      err_disp     <= accept && ev_disp;
      err_mismatch <= accept && ev_mismatch;
      err_range    <= accept && ev_range;
      err_jump     <= accept && ev_jump;
      if (accept) begin
        have_last_reg <= 1'b1;
        last_reg      <= sample_reg;
        status_mode   <= s_mode;
        status_fan    <= s_fan;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error and change counter. A clr arriving with a new event
  // clears the old history but keeps the new event.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky   <= 1'b0;
      change_count <= 8'd0;
    end else begin
      if (accept) begin
        err_sticky <= (err_sticky && !clr) || ev_any;
        if (clr) begin
          change_count <= 8'd1;
        end else if (change_count != 8'hFF) begin
          change_count <= change_count + 8'd1;
        end
      end else if (clr) begin
        err_sticky   <= 1'b0;
        change_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_smart_ac_status_decoder.sv
// Testbench for smart_ac_status_decoder (STABLE_CYCLES = 4).
// Directed scenarios followed by randomized tuples, all checked every cycle
// against a run-length based reference model.

module tb_smart_ac_status_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = '0;
  logic [2:0] fan = '0;
  logic [6:0] disp = '0;
  logic       clr = 1'b0;
  logic       status_valid;
  logic [2:0] status_mode;
  logic [2:0] status_fan;
  logic       err_disp;
  logic       err_mismatch;
  logic       err_range;
  logic       err_jump;
  logic       err_sticky;
  logic [7:0] change_count;

  smart_ac_status_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .fan          (fan),
    .disp         (disp),
    .clr          (clr),
    .status_valid (status_valid),
    .status_mode  (status_mode),
    .status_fan   (status_fan),
    .err_disp     (err_disp),
    .err_mismatch (err_mismatch),
    .err_range    (err_range),
    .err_jump     (err_jump),
    .err_sticky   (err_sticky),
    .change_count (change_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_pulse = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_run;        // consecutive identical samples since reset
  logic [12:0] m_prev;
  bit         m_have_last;
  logic [2:0] m_last_mode;
  logic [12:0] m_last;
  logic [2:0] m_mode, m_fan;
  bit         m_valid, m_edisp, m_emis, m_erange, m_ejump, m_sticky;
  int         m_count;

  function automatic int seg_digit(input logic [6:0] d);
    logic [6:0] pats [5];
    pats = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    for (int i = 0; i < 5; i++) if (d == pats[i]) return i;
    return -1;
  endfunction

  function automatic logic [6:0] seg_of(input int dig);
    logic [6:0] pats [5];
    pats = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    return pats[dig];
  endfunction

  task automatic model_reset();
    m_run = 0; m_prev = '0; m_have_last = 0; m_last = '0; m_last_mode = 0;
    m_mode = 0; m_fan = 0; m_valid = 0; m_edisp = 0; m_emis = 0;
    m_erange = 0; m_ejump = 0; m_sticky = 0; m_count = 0;
  endtask

  task automatic check_outputs();
    check_val("status_valid", int'(status_valid), int'(m_valid));
    check_val("status_mode", int'(status_mode), int'(m_mode));
    check_val("status_fan", int'(status_fan), int'(m_fan));
    check_val("err_flags", int'({err_disp, err_mismatch, err_range, err_jump}),
              int'({m_edisp, m_emis, m_erange, m_ejump}));
    check_val("err_sticky", int'(err_sticky), int'(m_sticky));
    check_val("change_count", int'(change_count), m_count);
  endtask

  // Apply one tuple for one clock edge, predict the outcome, then check.
  task automatic cycle(input logic [2:0] m, input logic [2:0] f,
                       input logic [6:0] d, input bit c);
    logic [12:0] tup;
    int dig, tm, delta;
    bit any;
    mode = m; fan = f; disp = d; clr = c;
    tup = {m, f, d};
    // A pulse happens when the last STABLE samples were one run and that
    // tuple is new relative to the last reported one.
    m_valid = (m_run == STABLE) && (!m_have_last || m_prev != m_last);
    m_edisp = 0; m_emis = 0; m_erange = 0; m_ejump = 0;
    if (m_valid) begin
      tm  = int'(m_prev[12:10]);
      dig = seg_digit(m_prev[6:0]);
      m_edisp  = (dig < 0);
      m_emis   = (dig >= 0) && (dig != tm);
      m_erange = (tm > 4);
      delta = tm - int'(m_last_mode);
      if (delta < 0) delta = -delta;
      m_ejump  = m_have_last && (tm != 0) && (delta > 1);
      any = m_edisp | m_emis | m_erange | m_ejump;
      m_sticky = (c ? 1'b0 : m_sticky) | any;
      m_count  = c ? 1 : (m_count < 255 ? m_count + 1 : 255);
      m_have_last = 1; m_last = m_prev; m_last_mode = m_prev[12:10];
      m_mode = m_prev[12:10]; m_fan = m_prev[9:7];
      n_pulse++;
    end else if (c) begin
      m_sticky = 0; m_count = 0;
    end
    if (m_run > 0 && tup == m_prev) m_run = (m_run < 1000) ? m_run + 1 : 1000;
    else m_run = 1;
    m_prev = tup;
    @(posedge clk);
    #1;
    check_outputs();
    $display("cyc mode=%0d fan=%0d disp=%07b clr=%0d -> valid=%0d smode=%0d err=%b%b%b%b sticky=%0d cnt=%0d",
             m, f, d, c, status_valid, status_mode, err_disp, err_mismatch,
             err_range, err_jump, err_sticky, change_count);
  endtask

  task automatic hold(input logic [2:0] m, input logic [2:0] f,
                      input logic [6:0] d, input int n);
    for (int i = 0; i < n; i++) cycle(m, f, d, 1'b0);
  endtask

  // Asynchronous reset applied and released between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses_before;
    int m, hlen, dig;
    logic [6:0] d;
    model_reset();
    mode = 3'd0; fan = 3'd0; disp = 7'b0111111;
    @(posedge clk);
    #1;
    do_reset();

    // Stable off-state after reset: one pulse on the 5th edge.
    hold(3'd0, 3'd0, 7'b0111111, 8);
    check_val("boot_pulses", n_pulse, 1);

    // Step 0 -> 1 -> 2 with matching display.
    hold(3'd1, 3'd2, seg_of(1), 10);
    hold(3'd2, 3'd2, seg_of(2), 10);
    check_val("step_count", int'(change_count), 3);

    // Fast toggling never settles; then hold 3.
    pulses_before = n_pulse;
    for (int i = 0; i < 12; i++)
      cycle((i % 2) ? 3'd1 : 3'd2, 3'd1, (i % 2) ? seg_of(1) : seg_of(2), 1'b0);
    check_val("toggle_no_pulse", n_pulse - pulses_before, 0);
    hold(3'd3, 3'd1, seg_of(3), 8);

    // Error scenarios.
    hold(3'd2, 3'd1, seg_of(3), 8);        // mismatch
    hold(3'd1, 3'd1, seg_of(1), 8);
    hold(3'd4, 3'd1, seg_of(4), 8);        // jump 1 -> 4
    hold(3'd5, 3'd1, 7'b1111111, 8);       // range + bad display
    cycle(3'd5, 3'd1, 7'b1111111, 1'b1);   // clr
    check_val("sticky_after_clr", int'(err_sticky), 0);

    // Saturate the counter with alternating legal tuples.
    for (int i = 0; i < 260; i++)
      hold((i % 2) ? 3'd1 : 3'd0, 3'd3, (i % 2) ? seg_of(1) : seg_of(0), 5);
    check_val("count_sat", int'(change_count), 255);
    // clr on the edge that produces the next pulse.
    hold(3'd1, 3'd4, seg_of(1), 4);
    cycle(3'd1, 3'd4, seg_of(1), 1'b1);
    check_val("clr_with_pulse", int'(change_count), 1);
    hold(3'd1, 3'd4, seg_of(1), 3);

    // Reset in the middle of settling, then the same tuple again.
    hold(3'd2, 3'd5, seg_of(2), 3);
    do_reset();
    hold(3'd2, 3'd5, seg_of(2), 8);
    check_val("post_reset_count", int'(change_count), 1);

    // Randomized tuples with random hold lengths and occasional clr.
    for (int t = 0; t < 150; t++) begin
      m = $urandom_range(0, 5);
      if ($urandom_range(0, 4) == 0) d = 7'($urandom);
      else begin
        dig = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : (m > 4 ? 4 : m);
        d = seg_of(dig);
      end
      hlen = $urandom_range(1, 7);
      for (int k = 0; k < hlen; k++)
        cycle(3'(m), 3'($urandom_range(0, 1)), d, ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/smart_ac_status_decoder.md
SMART_AC_STATUS_DECODER -- requirements
Module: smart_ac_status_decoder

Interface
- REQ-001: Parameter STABLE_CYCLES, default 4, range 2..15: number of consecutive identical samples before a status tuple is accepted.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: mode  input  3  controller mode being monitored; legal values 0..4.
- REQ-005: fan  input  3  fan-speed code being monitored; passed through, not interpreted.
- REQ-006: disp  input  7  seven-segment pattern being monitored, active-high, bit order {g,f,e,d,c,b,a}.
- REQ-007: clr  input  1  synchronous clear of the sticky error flag and of change_count.
- REQ-008: status_valid  output  1  one-cycle pulse; a new stable tuple has been accepted.
- REQ-009: status_mode  output  3  mode of the last accepted tuple.
- REQ-010: status_fan  output  3  fan of the last accepted tuple.
- REQ-011: err_disp / err_mismatch / err_range / err_jump  output  1 each  per-event error flags, valid only while status_valid=1.
- REQ-012: err_sticky  output  1  OR of every error reported since the last reset or clr.
- REQ-013: change_count  output  8  number of accepted tuples, saturating at 255.

Function
- REQ-014: mode, fan and disp shall be registered as one 13-bit sample tuple every cycle; all checking shall use registered samples only.
- REQ-015: The FSM shall have exactly two states: SETTLE and LOCKED.
- REQ-016: In either state, a sample that differs from the previous sample shall load the stability counter with 1 and move the FSM to SETTLE.
- REQ-017: In SETTLE, each sample equal to the previous sample shall increment the counter; on reaching STABLE_CYCLES the FSM shall go to LOCKED.
- REQ-018: On the SETTLE->LOCKED transition, the block shall accept the tuple and pulse status_valid in the next cycle, but only if the tuple differs from the last accepted tuple or no tuple has been accepted since reset.
- REQ-019: Latency: with a new tuple on the inputs from rising edge t and held constant, status_valid shall assert at edge t+STABLE_CYCLES+1; a change before then shall restart the count with no pulse.
- REQ-020: In LOCKED, the FSM shall stay in LOCKED and emit no further pulses while the samples remain unchanged.
- REQ-021: status_mode and status_fan shall update in the same cycle as the status_valid pulse and hold their values otherwise.
- REQ-022: Display decoding shall use these exact patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110; any other pattern shall set err_disp.
- REQ-023: err_mismatch shall be set when disp is legal and its decoded digit is not equal to mode.
- REQ-024: err_range shall be set when mode is greater than 4.
- REQ-025: err_jump shall be set when a previous accepted tuple exists, the new mode is not 0, and the new mode differs from the previous accepted mode by more than 1; a transition to 0 is always legal.
- REQ-026: change_count shall increment on each status_valid pulse and hold at 255.
- REQ-027: err_sticky shall be set by any per-event error.
- REQ-028: clr shall zero err_sticky and change_count; if clr coincides with a status_valid pulse, the new event shall be counted (count=1) and its errors shall set err_sticky.

Reset
- REQ-029: While rst_n=0, the block shall hold: FSM=SETTLE, counter=0, sample register=0, no tuple accepted, status_valid=0, status_mode=0, status_fan=0, all err_*=0, change_count=0.
- REQ-030: If rst_n is asserted mid-settle, the partial count shall be discarded; after release, the first stable tuple shall be reported even if it equals the value from before the reset.

Verification (STABLE_CYCLES=4)
- REQ-031: After reset, hold mode=0, fan=0, disp=0111111 -> exactly one status_valid at the 5th edge after release, no errors, change_count=1.
- REQ-032: Step mode 0->1->2, each held 10 cycles with matching disp -> two pulses, status_mode=1 then 2, change_count=3, err_sticky=0.
- REQ-033: Change mode on alternate cycles for 12 cycles, then hold 3 -> no pulse during toggling, exactly one pulse 5 edges after the final change.
- REQ-034: Hold mode=2 with disp=1001111 -> pulse with err_mismatch=1; then mode=4 from 1 -> err_jump=1; then mode=5 -> err_range=1 and err_disp=1; err_sticky=1 until clr.
- REQ-035: Drive 260 alternating legal tuples -> change_count=255; assert clr coincident with a pulse -> change_count=1.
- REQ-036: Assert rst_n=0 at the 3rd stable cycle of a new tuple, release, hold the same tuple -> pulse 5 edges after release, change_count=1.
